// File: rtl/irq_ctrl.sv
// irq_ctrl: up to 8 interrupt sources (edge/level, mask, pending, line map) onto 4 CPU lines.
// Define IRQ_CTRL_SYNC_EN to insert a 2-flop synchronizer on src_irq.
module irq_ctrl #(
  parameter int         NUM_SRC   = 8,
  parameter logic [7:0] BASE_ADDR = 8'h20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [15:0]        io_address,
  input  logic [7:0]         io_din,
  input  logic               io_write_en,
  input  logic               io_read_en,
  output logic [7:0]         io_dout,
  output logic [3:0]         irq_out,
  input  logic [3:0]         irq_clr
);

  localparam logic [7:0]  IMPL     = 8'((9'd1 << NUM_SRC) - 9'd1);
  localparam logic [15:0] MAP_IMPL = 16'((17'd1 << (2 * NUM_SRC)) - 17'd1);

  logic [7:0]      src_w, s, prev, edge_det;
  logic [7:0]      mask, pend, edge_mode, pend_nxt, clr_bits, rdata;
  logic [15:0]     map;
  logic [3:0][7:0] cause, cause_nxt, elig;
  logic [3:0]      clr_prev, ack, req;
  logic [8:0]      addr_lo;
  logic [7:0]      off;
  logic            sel, wr_mask, wr_pend, wr_edge, wr_map_lo, wr_map_hi;

  always_comb begin
    src_w = '0;
    src_w[NUM_SRC-1:0] = src_irq;
  end

`ifdef IRQ_CTRL_SYNC_EN
  logic [7:0] sync1, sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src_w & IMPL;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = src_w & IMPL;
`endif

  assign edge_det = s & ~prev;

  assign addr_lo   = {1'b0, io_address[7:0]};
  assign sel       = (io_address[15:8] == 8'h10) &&
                     (addr_lo >= {1'b0, BASE_ADDR}) &&
                     (addr_lo <= {1'b0, BASE_ADDR} + 9'd8);
  assign off       = io_address[7:0] - BASE_ADDR;
  assign wr_mask   = io_write_en && sel && (off == 8'd0);
  assign wr_pend   = io_write_en && sel && (off == 8'd1);
  assign wr_edge   = io_write_en && sel && (off == 8'd2);
  assign wr_map_lo = io_write_en && sel && (off == 8'd3);
  assign wr_map_hi = io_write_en && sel && (off == 8'd4);

  // Lowest eligible index wins an acknowledge; x & -x isolates it for the clear.
  always_comb begin
    ack       = irq_clr & ~clr_prev;
    clr_bits  = '0;
    cause_nxt = cause;
    elig      = '0;
    req       = '0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++)
        elig[k][i] = pend[i] & mask[i] & (map[2*i +: 2] == 2'(k));
      req[k] = |elig[k];
      if (ack[k]) begin
        cause_nxt[k] = 8'h00;
        for (int i = 7; i >= 0; i--)
          if (elig[k][i]) cause_nxt[k] = {5'b10000, 3'(i)};
        clr_bits = clr_bits | (elig[k] & (~elig[k] + 8'd1));
      end
    end
    if (wr_pend) clr_bits = clr_bits | io_din;
    pend_nxt = ((edge_mode & ((pend & ~clr_bits) | edge_det)) | (~edge_mode & s)) & IMPL;
  end

  always_comb begin
    rdata = 8'h00;
    case (off)
      8'd0:    rdata = mask;
      8'd1:    rdata = pend;
      8'd2:    rdata = edge_mode;
      8'd3:    rdata = map[7:0];
      8'd4:    rdata = map[15:8];
      8'd5:    rdata = cause[0];
      8'd6:    rdata = cause[1];
      8'd7:    rdata = cause[2];
      8'd8:    rdata = cause[3];
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev      <= '0;
      clr_prev  <= '0;
      pend      <= '0;
      cause     <= '0;
      irq_out   <= '0;
      io_dout   <= '0;
      mask      <= '0;
      edge_mode <= '0;
      map       <= '0;
    end else begin
      prev     <= s;
      clr_prev <= irq_clr;
      pend     <= pend_nxt;
      cause    <= cause_nxt;
      irq_out  <= req;
      if (io_read_en) io_dout <= sel ? rdata : 8'h00;
      if (wr_mask)    mask      <= io_din & IMPL;
      if (wr_edge)    edge_mode <= io_din & IMPL;
      if (wr_map_lo)  map[7:0]  <= io_din & MAP_IMPL[7:0];
      if (wr_map_hi)  map[15:8] <= io_din & MAP_IMPL[15:8];
    end
  end

endmodule
